floo_id_order_tracker: RTL

- Per-txnID ordering guard for the network interface when the RoB type is NoRoB. It generalises that mode to a parametrised ID count, outstanding depth and destination width.
- Sits on the outgoing Ax path of the chimney, between the AXI request cut and the flit packer.
- Stalls a new transaction whose txnID already has outstanding transactions to a different destination, or whose per-ID counter is full.
- Monitors response handshakes to retire transactions.

---
 rtl/floo_id_order_tracker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/floo_id_order_tracker.sv
// Per-txnID ordering guard for the NoRoB chimney Ax path: stalls requests that would reorder
// across destinations or overflow the per-ID outstanding count. Optional: FLOO_ID_ORDER_TRACKER_STALL_CNT_EN.
module floo_id_order_tracker #(
    parameter int unsigned  IdWidth      = 4,
    parameter int unsigned  DstWidth     = 8,
    parameter int unsigned  MaxTxnsPerId = 4,
    localparam int unsigned CntWidth     = $clog2(MaxTxnsPerId + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ax_valid_i,
    output logic                ax_ready_o,
    input  logic [IdWidth-1:0]  ax_id_i,
    input  logic [DstWidth-1:0] ax_dst_i,
    output logic                ax_valid_o,
    input  logic                ax_ready_i,
    input  logic                rsp_valid_i,
    input  logic                rsp_ready_i,
    input  logic [IdWidth-1:0]  rsp_id_i,
    input  logic                rsp_last_i,
    output logic                idle_o,
    output logic                err_o,
    output logic [31:0]         stall_cnt_o
);

    localparam int unsigned         NumIds = 2 ** IdWidth;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxnsPerId);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [CntWidth-1:0] r_cnt [NumIds];
    logic [DstWidth-1:0] r_dst [NumIds];
    logic                r_err;

    logic [CntWidth-1:0] w_cntNext [NumIds];
    logic [NumIds-1:0]   w_incVec;
    logic [NumIds-1:0]   w_decVec;
    logic                w_stall;
    logic                w_push;
    logic                w_pop;
    logic                w_idle;

    // Stall depends only on registered state, so there is no rsp->ax combinational path.
    assign w_stall = ((r_cnt[ax_id_i] != '0) && (r_dst[ax_id_i] != ax_dst_i))
                   || (r_cnt[ax_id_i] == CntMax);

    assign ax_valid_o = ax_valid_i && !w_stall;
    assign ax_ready_o = ax_ready_i && !w_stall;

    assign w_push = ax_valid_i && ax_ready_i && !w_stall;
    assign w_pop  = rsp_valid_i && rsp_ready_i && rsp_last_i;

    always_comb begin
        w_incVec = '0;
        w_decVec = '0;
        for (int i = 0; i < NumIds; i++) begin
            w_incVec[i] = w_push && (ax_id_i == IdWidth'(i));
            w_decVec[i] = w_pop && (rsp_id_i == IdWidth'(i));
        end
    end

    // A pop against an empty counter never wraps; paired with a push it leaves exactly one outstanding.
    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            w_cntNext[i] = r_cnt[i];
            if (w_incVec[i] && w_decVec[i]) begin
                if (r_cnt[i] == '0) begin
                    w_cntNext[i] = CntOne;
                end
            end else if (w_incVec[i]) begin
                w_cntNext[i] = r_cnt[i] + CntOne;
            end else if (w_decVec[i] && (r_cnt[i] != '0)) begin
                w_cntNext[i] = r_cnt[i] - CntOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumIds; i++) begin
                r_cnt[i] <= '0;
                r_dst[i] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                r_cnt[i] <= w_cntNext[i];
                if (w_incVec[i]) begin
                    r_dst[i] <= ax_dst_i;
                end
            end
            if (w_pop && (r_cnt[rsp_id_i] == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_idle = 1'b1;
        for (int i = 0; i < NumIds; i++) begin
            if (r_cnt[i] != '0) begin
                w_idle = 1'b0;
            end
        end
    end

    assign idle_o = w_idle;
    assign err_o  = r_err;

`ifdef FLOO_ID_ORDER_TRACKER_STALL_CNT_EN
    logic [31:0] r_stallCnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stallCnt <= '0;
        end else if (ax_valid_i && w_stall && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stallCnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
